// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPSCPU stack unit.
// Op encoding follows {push, pop} directly so decode is a plain cast.
package mips_pkg;

  localparam int STACK_WIDTH = 32;
  localparam int STACK_DEPTH = 16;

  typedef enum logic [1:0] {
    NOP     = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/hw_stack_mem.sv
// Stack storage: DEPTH x WIDTH, synchronous write, asynchronous read.
// Addresses are pointer-width; out-of-range reads return 0 and
// out-of-range writes are dropped, so callers may pass sp-1 when empty.
module hw_stack_mem
  import mips_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  parameter int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] DEPTH_W = PTR_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we && (waddr < DEPTH_W)) begin
      mem[waddr[AW-1:0]] <= wdata;
    end
  end

  // Asynchronous read of the top-of-stack slot.
  always_comb begin
    rdata = '0;
    if (raddr < DEPTH_W) begin
      rdata = mem[raddr[AW-1:0]];
    end
  end

endmodule

// File: rtl/hw_stack_unit.sv
// Parametrised LIFO stack for MIPSCPU call/return and push/pop.
// Holds the stack pointer, sticky overflow/underflow flags and, when
// HW_STACK_WATERMARK_EN is defined, a high-water occupancy register.
// Push and pop together on a non-empty stack replace the top entry.
module hw_stack_unit
  import mips_pkg::*;
#(
  parameter  int WIDTH = STACK_WIDTH,
  parameter  int DEPTH = STACK_DEPTH,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] top,
  output logic [PTR_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             stack_overflow,
  output logic             stack_underflow
`ifdef HW_STACK_WATERMARK_EN
  ,
  output logic [PTR_W-1:0] high_water
`endif
);

  localparam logic [PTR_W-1:0] DEPTH_W = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE_W   = PTR_W'(1);

  stack_op_t        op;
  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_m1;
  logic [PTR_W-1:0] next_sp;
  logic [PTR_W-1:0] waddr;
  logic             mem_we;
  logic             set_ovf;
  logic             set_unf;
  logic [WIDTH-1:0] rd_data;

  assign op    = decode_op(push, pop);
  assign sp_m1 = sp - ONE_W;
  assign count = sp;
  assign empty = (sp == '0);
  assign full  = (sp == DEPTH_W);
  assign top   = empty ? '0 : rd_data;

  // Decode the requested op against current occupancy into pointer/write/flag actions.
  always_comb begin
    next_sp = sp;
    waddr   = sp;
    mem_we  = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (op)
      PUSH: begin
        if (full) begin
          set_ovf = 1'b1;
        end else begin
          mem_we  = 1'b1;
          next_sp = sp + ONE_W;
        end
      end
      POP: begin
        if (empty) begin
          set_unf = 1'b1;
        end else begin
          next_sp = sp_m1;
        end
      end
      REPLACE: begin
        // On an empty stack the pop half is refused but the push still lands.
        mem_we = 1'b1;
        if (empty) begin
          set_unf = 1'b1;
          next_sp = sp + ONE_W;
        end else begin
          waddr = sp_m1;
        end
      end
      default: begin
        next_sp = sp;
      end
    endcase
  end

  hw_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we && !rst),
    .waddr (waddr),
    .wdata (push_data),
    .raddr (sp_m1),
    .rdata (rd_data)
  );

  // Pointer and sticky flags; a refusal in the same cycle beats clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp              <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      sp              <= next_sp;
      stack_overflow  <= set_ovf | (stack_overflow & ~clr_flags);
      stack_underflow <= set_unf | (stack_underflow & ~clr_flags);
    end
  end

`ifdef HW_STACK_WATERMARK_EN
  // High-water mark tracks the largest occupancy since reset or clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_water <= '0;
    end else if (clr_flags) begin
      high_water <= next_sp;
    end else if (next_sp > high_water) begin
      high_water <= next_sp;
    end
  end
`else
  // No occupancy history is kept in this build.
`endif

endmodule
